// File: rtl/sr_latch_driver.sv
// sr_latch_driver: registered, mutually exclusive S/R pulse driver with dead time and shadow state.
// Optional latch readback fault check is enabled by defining SR_READBACK_EN.
module sr_latch_driver #(
    parameter int PULSE_W = 4,
    parameter int DEAD_W  = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [1:0] i_cmd,
`ifdef SR_READBACK_EN
    input  logic       i_q_fb,
    output logic       o_fault,
`endif
    output logic       o_ready,
    output logic       o_s,
    output logic       o_r,
    output logic       o_q_shadow,
    output logic       o_busy
);
    localparam int MAXV = (PULSE_W > DEAD_W) ? PULSE_W : DEAD_W;
    localparam int CW = $clog2(MAXV + 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_PULSE = 2'd1, S_DEAD = 2'd2;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_s, r_r, r_q;
    logic          w_acc, w_set, w_done;
    assign w_acc  = i_valid && (r_state == S_IDLE) && (i_cmd != 2'b00);
    // TOGGLE resolves against the shadow at the acceptance edge
    assign w_set  = (i_cmd == 2'b01) || ((i_cmd == 2'b11) && !r_q);
    assign w_done = (r_cnt == '0);
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_q     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_acc) begin
                    r_state <= S_PULSE;
                    r_cnt   <= CW'(PULSE_W - 1);
                    r_s     <= w_set;
                    r_r     <= !w_set;
                end
                S_PULSE: if (w_done) begin
                    r_s     <= 1'b0;
                    r_r     <= 1'b0;
                    r_q     <= r_s;
                    r_state <= (DEAD_W > 0) ? S_DEAD : S_IDLE;
                    r_cnt   <= CW'((DEAD_W > 0) ? DEAD_W - 1 : 0);
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
                S_DEAD: if (w_done) r_state <= S_IDLE;
                        else r_cnt <= r_cnt - 1'b1;
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign o_ready    = (r_state == S_IDLE);
    assign o_busy     = (r_state != S_IDLE);
    assign o_s        = r_s;
    assign o_r        = r_r;
    assign o_q_shadow = r_q;
`ifdef SR_READBACK_EN
    logic r_post, r_fault, w_chk;
    // with no dead time the compare happens in the first idle cycle after the pulse
    assign w_chk = (DEAD_W > 0) ? ((r_state == S_DEAD) && w_done) : r_post;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_post  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_post <= (r_state == S_PULSE) && w_done;
            if (w_chk && (i_q_fb != r_q)) r_fault <= 1'b1;
        end
    end
    assign o_fault = r_fault;
`endif
endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: directed self-checking bench for sr_latch_driver (PULSE_W=4, DEAD_W=2).
module tb_sr_latch_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       ready, s, r, q_shadow, busy;
    int         n_chk = 0;
    int         n_err = 0;
    int         cnt_s, cnt_r;
`ifdef SR_READBACK_EN
    logic       fault;
    logic       latch_q = 1'b0;
    logic       fb_break = 1'b0;
    logic       q_fb;
    assign q_fb = latch_q & ~fb_break;
    always @(posedge clk) begin
        if (s) latch_q <= 1'b1;
        else if (r) latch_q <= 1'b0;
    end
`endif

    sr_latch_driver #(.PULSE_W(4), .DEAD_W(2)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_valid(valid),
        .i_cmd(cmd),
`ifdef SR_READBACK_EN
        .i_q_fb(q_fb),
        .o_fault(fault),
`endif
        .o_ready(ready),
        .o_s(s),
        .o_r(r),
        .o_q_shadow(q_shadow),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) chk("excl", 32'(s & r), 32'd0);

    initial begin
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_s", 32'(s), 0);
        chk("rst_r", 32'(r), 0);
        chk("rst_q", 32'(q_shadow), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(ready), 1);
`ifdef SR_READBACK_EN
        chk("rst_fault", 32'(fault), 0);
`endif
        // SET: accepted at edge k, then cycles k+1..k+7
        valid = 1'b1; cmd = 2'b01;
        for (int c = 1; c <= 7; c++) begin
            step();
            valid = 1'b0;
            chk("set_s", 32'(s), 32'(c <= 4));
            chk("set_r", 32'(r), 0);
            chk("set_q", 32'(q_shadow), 32'(c >= 5));
            chk("set_ready", 32'(ready), 32'(c >= 7));
            chk("set_busy", 32'(busy), 32'(c <= 6));
        end
        // RESET to return the shadow to 0
        valid = 1'b1; cmd = 2'b10; cnt_r = 0;
        for (int c = 1; c <= 7; c++) begin
            step();
            valid = 1'b0;
            cnt_r += int'(r);
            chk("res_s", 32'(s), 0);
        end
        chk("res_cnt", 32'(cnt_r), 4);
        chk("res_q", 32'(q_shadow), 0);
        // back-to-back TOGGLE with valid held
        valid = 1'b1; cmd = 2'b11;
        for (int c = 1; c <= 14; c++) begin
            step();
            chk("tgl_s", 32'(s), 32'(c >= 1 && c <= 4));
            chk("tgl_r", 32'(r), 32'(c >= 8 && c <= 11));
            chk("tgl_q", 32'(q_shadow), 32'(c >= 5 && c <= 11));
            chk("tgl_ready", 32'(ready), 32'(c == 7 || c == 14));
        end
        valid = 1'b0;
        // NOP in idle
        valid = 1'b1; cmd = 2'b00;
        for (int c = 1; c <= 2; c++) begin
            step();
            valid = 1'b0;
            chk("nop_ready", 32'(ready), 1);
            chk("nop_busy", 32'(busy), 0);
            chk("nop_sr", 32'({s, r}), 0);
        end
        // SET then RESET presented while busy
        valid = 1'b1; cmd = 2'b01;
        step();
        cmd = 2'b10;
        cnt_s = int'(s); cnt_r = int'(r);
        for (int c = 2; c <= 16; c++) begin
            step();
            if (r) valid = 1'b0;
            cnt_s += int'(s);
            cnt_r += int'(r);
        end
        valid = 1'b0;
        chk("busy_cnt_s", 32'(cnt_s), 4);
        chk("busy_cnt_r", 32'(cnt_r), 4);
        chk("busy_q", 32'(q_shadow), 0);
        chk("busy_ready", 32'(ready), 1);
        // SET to shadow 1, then refresh SET interrupted by reset
        valid = 1'b1; cmd = 2'b01;
        for (int c = 1; c <= 7; c++) begin
            step();
            valid = 1'b0;
        end
        chk("pre_q", 32'(q_shadow), 1);
        valid = 1'b1;
        step();
        valid = 1'b0;
        step();
        chk("mid_s", 32'(s), 1);
        rst = 1'b1;
        step();
        chk("mid_rst_s", 32'(s), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_q", 32'(q_shadow), 0);
        rst = 1'b0;
        step();
        chk("mid_ready", 32'(ready), 1);
        valid = 1'b1; cmd = 2'b01; cnt_s = 0;
        for (int c = 1; c <= 7; c++) begin
            step();
            valid = 1'b0;
            cnt_s += int'(s);
        end
        chk("post_cnt_s", 32'(cnt_s), 4);
        chk("post_q", 32'(q_shadow), 1);
`ifdef SR_READBACK_EN
        chk("fb_ok_fault", 32'(fault), 0);
        fb_break = 1'b1;
        valid = 1'b1; cmd = 2'b01;
        for (int c = 1; c <= 7; c++) begin
            step();
            valid = 1'b0;
            chk("fb_fault", 32'(fault), 32'(c >= 7));
        end
        fb_break = 1'b0;
        valid = 1'b1; cmd = 2'b10;
        for (int c = 1; c <= 7; c++) begin
            step();
            valid = 1'b0;
        end
        chk("fb_sticky", 32'(fault), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("fb_clear", 32'(fault), 0);
`endif
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
